// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with operand handshake, operand-wait timeout and multi-cycle multiply
module alu_pipe #(
  parameter int WIDTH   = 8,
  parameter int CMD_W   = 4,
  parameter int TIMEOUT = 16,
  parameter int MUL_LAT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               mode,
  input  logic [CMD_W-1:0]   cmd,
  input  logic [1:0]         inp_valid,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  input  logic               cin,
  output logic [2*WIDTH-1:0] res,
  output logic               cout,
  output logic               oflow,
  output logic               g,
  output logic               l,
  output logic               e,
  output logic               err,
  output logic               out_valid,
  output logic               busy
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(TIMEOUT + MUL_LAT);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, WAIT, EXEC, DONE} state_t;

  // Operand bits a command needs: [0]=opa, [1]=opb
  function automatic logic [1:0] need_of(input logic m, input logic [CMD_W-1:0] c);
    int ci;
    ci = int'(c);
    if (m) return (ci == 4 || ci == 5) ? 2'b01 : (ci == 6 || ci == 7) ? 2'b10 : 2'b11;
    return (ci == 6 || ci == 8 || ci == 9) ? 2'b01 : (ci == 7 || ci == 10 || ci == 11) ? 2'b10 : 2'b11;
  endfunction

  function automatic logic is_mul(input logic m, input logic [CMD_W-1:0] c);
    return m && (int'(c) == 9 || int'(c) == 10);
  endfunction

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               cin_q, cin_d;
  logic [1:0]         have_q, have_d, need_q, need_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               cout_q, cout_d, oflow_q, oflow_d;
  logic               g_q, g_d, l_q, l_d, e_q, e_d, err_q, err_d, ov_q, ov_d;

  logic [WIDTH:0]     ax, bx, cx, add_s, addc_s, sub_s, subc_s;
  logic [WIDTH:0]     inc_a, dec_a, inc_b, dec_b;
  logic [2*WIDTH-1:0] mul_inc, mul_shl;
  logic [WIDTH-1:0]   rol, ror, lres;
  logic [SW-1:0]      sh;
  logic               rot_err;
  logic [2*WIDTH-1:0] r_res;
  logic               r_cout, r_oflow, r_g, r_l, r_e, r_err;
  logic [1:0]         in_need, got, avail;
  logic               finish;

  // Shared arithmetic on the captured operands; carry/borrow live in the extra top bit
  always_comb begin
    ax      = {1'b0, a_q};
    bx      = {1'b0, b_q};
    cx      = {{WIDTH{1'b0}}, cin_q};
    add_s   = ax + bx;
    addc_s  = ax + bx + cx;
    sub_s   = ax - bx;
    subc_s  = ax - bx - cx;
    inc_a   = ax + ONE;
    dec_a   = ax - ONE;
    inc_b   = bx + ONE;
    dec_b   = bx - ONE;
    mul_inc = {{(WIDTH-1){1'b0}}, inc_a} * {{(WIDTH-1){1'b0}}, inc_b};
    mul_shl = {{(WIDTH-1){1'b0}}, a_q, 1'b0} * {{WIDTH{1'b0}}, b_q};
    sh      = b_q[SW-1:0];
    rot_err = |(b_q >> SW);
    rol     = (a_q << sh) | (a_q >> (WIDTH - int'(sh)));
    ror     = (a_q >> sh) | (a_q << (WIDTH - int'(sh)));
  end

  // Result and flag selection; flags not belonging to the command stay 0
  always_comb begin
    r_res   = '0;
    r_cout  = 1'b0;
    r_oflow = 1'b0;
    r_g     = 1'b0;
    r_l     = 1'b0;
    r_e     = 1'b0;
    r_err   = 1'b0;
    lres    = '0;
    if (mode_q) begin
      case (int'(cmd_q))
        0:  begin r_res = {{(WIDTH-1){1'b0}}, add_s};  r_cout = add_s[WIDTH];   end
        1:  begin r_res = {{WIDTH{1'b0}}, sub_s[WIDTH-1:0]};  r_oflow = sub_s[WIDTH];  end
        2:  begin r_res = {{(WIDTH-1){1'b0}}, addc_s}; r_cout = addc_s[WIDTH];  end
        3:  begin r_res = {{WIDTH{1'b0}}, subc_s[WIDTH-1:0]}; r_oflow = subc_s[WIDTH]; end
        4:  begin r_res = {{WIDTH{1'b0}}, inc_a[WIDTH-1:0]};  r_cout = inc_a[WIDTH];   end
        5:  begin r_res = {{WIDTH{1'b0}}, dec_a[WIDTH-1:0]};  r_oflow = dec_a[WIDTH];  end
        6:  begin r_res = {{WIDTH{1'b0}}, inc_b[WIDTH-1:0]};  r_cout = inc_b[WIDTH];   end
        7:  begin r_res = {{WIDTH{1'b0}}, dec_b[WIDTH-1:0]};  r_oflow = dec_b[WIDTH];  end
        8:  begin r_g = a_q > b_q; r_l = a_q < b_q; r_e = a_q == b_q; end
        9:  r_res = mul_inc;
        10: r_res = mul_shl;
        default: r_err = 1'b1;
      endcase
    end else begin
      case (int'(cmd_q))
        0:  lres = a_q & b_q;
        1:  lres = ~(a_q & b_q);
        2:  lres = a_q | b_q;
        3:  lres = ~(a_q | b_q);
        4:  lres = a_q ^ b_q;
        5:  lres = ~(a_q ^ b_q);
        6:  lres = ~a_q;
        7:  lres = ~b_q;
        8:  lres = a_q >> 1;
        9:  lres = a_q << 1;
        10: lres = b_q >> 1;
        11: lres = b_q << 1;
        12: begin lres = rol; r_err = rot_err; end
        13: begin lres = ror; r_err = rot_err; end
        default: r_err = 1'b1;
      endcase
      r_res = {{WIDTH{1'b0}}, lres};
    end
  end

  // Control: capture operands, wait for a missing one, count multiply latency, publish results
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    cmd_d   = cmd_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    have_d  = have_q;
    need_d  = need_q;
    res_d   = res_q;
    cout_d  = cout_q;
    oflow_d = oflow_q;
    g_d     = g_q;
    l_d     = l_q;
    e_d     = e_q;
    err_d   = err_q;
    ov_d    = 1'b0;
    finish  = 1'b0;
    in_need = need_of(mode, cmd);
    got     = inp_valid & in_need;
    avail   = have_q | (inp_valid & need_q);
    case (state_q)
      IDLE: if (got != 2'b00) begin
        mode_d  = mode;
        cmd_d   = cmd;
        cin_d   = cin;
        need_d  = in_need;
        have_d  = got;
        cnt_d   = '0;
        a_d     = got[0] ? opa : a_q;
        b_d     = got[1] ? opb : b_q;
        state_d = (got != in_need) ? WAIT : is_mul(mode, cmd) ? EXEC : DONE;
      end
      WAIT: begin
        a_d    = (need_q[0] && !have_q[0] && inp_valid[0]) ? opa : a_q;
        b_d    = (need_q[1] && !have_q[1] && inp_valid[1]) ? opb : b_q;
        have_d = avail;
        cnt_d  = cnt_q + CW'(1);
        if (avail == need_q) begin
          cnt_d   = '0;
          state_d = is_mul(mode_q, cmd_q) ? EXEC : DONE;
        end else if (cnt_q == TO_LAST) begin
          state_d = IDLE;
          res_d   = '0;
          cout_d  = 1'b0;
          oflow_d = 1'b0;
          g_d     = 1'b0;
          l_d     = 1'b0;
          e_d     = 1'b0;
          err_d   = 1'b1;
          ov_d    = 1'b1;
        end
      end
      EXEC: begin
        cnt_d  = cnt_q + CW'(1);
        finish = cnt_q == MUL_LAST;
      end
      DONE: finish = 1'b1;
      default: state_d = IDLE;
    endcase
    if (finish) begin
      state_d = IDLE;
      res_d   = r_res;
      cout_d  = r_cout;
      oflow_d = r_oflow;
      g_d     = r_g;
      l_d     = r_l;
      e_d     = r_e;
      err_d   = r_err;
      ov_d    = 1'b1;
    end
  end

  // State and output registers; ce=0 freezes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      cmd_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      have_q  <= '0;
      need_q  <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      oflow_q <= 1'b0;
      g_q     <= 1'b0;
      l_q     <= 1'b0;
      e_q     <= 1'b0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      cmd_q   <= cmd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      have_q  <= have_d;
      need_q  <= need_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      oflow_q <= oflow_d;
      g_q     <= g_d;
      l_q     <= l_d;
      e_q     <= e_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
    end
  end

  assign res       = res_q;
  assign cout      = cout_q;
  assign oflow     = oflow_q;
  assign g         = g_q;
  assign l         = l_q;
  assign e         = e_q;
  assign err       = err_q;
  assign out_valid = ov_q & ce;
  assign busy      = (state_q == WAIT) || (state_q == EXEC);
endmodule
